seg_scan_ctrl: RTL



---
 rtl/seg_pkg.sv | 29 ++
 rtl/led7segmentos.sv | 11 +
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: glyphs, slot phase,
// and the leading-zero mask helper.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {a,b,c,d,e,f,g}, MSB = a
  localparam logic [6:0] HEX_GLYPH [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic {BLANK, ON} phase_e;

  // Bit i set when nibbles i..digits-1 are all zero; digit 0 is never masked.
  function automatic logic [7:0] lz_mask(input logic [31:0] val,
                                         input int unsigned digits);
    logic run;
    lz_mask = '0;
    run     = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (i < int'(digits)) begin
        run        = run & (val[4*i +: 4] == 4'h0);
        lz_mask[i] = run;
      end
    end
  endfunction

endpackage

// File: rtl/led7segmentos.sv
// Hex nibble to active-low 7-segment glyph, {a..g} with a in the MSB.
module led7segmentos
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_GLYPH[hex_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// frame-synchronous snapshot update, per-slot blanking and leading-zero blanking.
//
// phase | meaning
// BLANK | slot counter < BLANK_CYCLES, all anodes off
// ON    | selected anode driven low unless the digit is dark
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_blank,
  input  logic                  load,
  output logic                  frame_start,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments,
  output logic                  dp
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_vld_q, pend_vld_d;

  logic [DIGITS-1:0]   anodes_q, anodes_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                fs_q, fs_d;

  phase_e              phase;
  logic                slot_end, frame_end;
  logic [31:0]         val_wide;
  logic [7:0]          lz;
  logic                dark;
  logic [3:0]          nib;
  logic [6:0]          dec_seg;

  led7segmentos u_dec (
    .hex_i (nib),
    .seg_o (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_vld_q   <= 1'b0;
      anodes_q     <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_vld_q   <= pend_vld_d;
      anodes_q     <= anodes_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fs_q         <= fs_d;
    end
  end

  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    frame_end    = slot_end && (idx_q == IDX_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_vld_d   = pend_vld_q;
    if (load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
    // A load on the boundary bypasses pending so it shows in the new frame.
    if (frame_end) begin
      if (load) begin
        shadow_val_d = value_in;
        shadow_dp_d  = dp_in;
        pend_vld_d   = 1'b0;
      end else if (pend_vld_q) begin
        shadow_val_d = pend_val_q;
        shadow_dp_d  = pend_dp_q;
        pend_vld_d   = 1'b0;
      end
    end
  end

  always_comb begin
    phase    = (cnt_q < BLANK_END) ? BLANK : ON;
    val_wide = '0;
    val_wide[4*DIGITS-1:0] = shadow_val_q;
    lz       = lz_mask(val_wide, DIGITS);
    dark     = !digit_en[idx_q] || (lz_blank && lz[idx_q]);
    nib      = shadow_val_q[{idx_q, 2'b00} +: 4];
    fs_d     = (cnt_q == '0) && (idx_q == '0);
    anodes_d = '1;
    seg_d    = SEG_OFF;
    dp_d     = 1'b1;
    if (phase == ON) begin
      seg_d = dec_seg;
      dp_d  = ~shadow_dp_q[idx_q];
      if (!dark) begin
        anodes_d[idx_q] = 1'b0;
      end
    end
  end

  assign frame_start = fs_q;
  assign anodes      = anodes_q;
  assign segments    = seg_q;
  assign dp          = dp_q;

endmodule
